// File: rtl/decryption_stream_core.sv
// decryption_stream_core: serialises MST_DWIDTH-bit master words into
// SYS_DWIDTH-bit symbols (one per clock) and Caesar-decrypts each symbol with a
// per-channel key. Owns a small register file (SELECT, ORDER, COUNT, KEY_i).
// Ports:
//   clk_sys, rst_n          clock, async active-low reset
//   data_i, valid_i, busy   master word input; busy=1 means the word is not taken
//   data_o, valid_o         decrypted symbol stream
//   addr, read, write, wdata register access strobes
//   rdata, done, error      access response, one cycle after the strobe
module decryption_stream_core #(
  parameter int unsigned addr_witdth = 8,
  parameter int unsigned reg_width   = 16,
  parameter int unsigned MST_DWIDTH  = 32,
  parameter int unsigned SYS_DWIDTH  = 8,
  parameter int unsigned NUM_CH      = 4
) (
  input  logic                   clk_sys,
  input  logic                   rst_n,
  input  logic [MST_DWIDTH-1:0]  data_i,
  input  logic                   valid_i,
  output logic                   busy,
  output logic [SYS_DWIDTH-1:0]  data_o,
  output logic                   valid_o,
  input  logic [addr_witdth-1:0] addr,
  input  logic                   read,
  input  logic                   write,
  input  logic [reg_width-1:0]   wdata,
  output logic [reg_width-1:0]   rdata,
  output logic                   done,
  output logic                   error
);

  localparam int unsigned N     = MST_DWIDTH / SYS_DWIDTH;
  localparam int unsigned K_W   = $clog2(N);
  localparam int unsigned SEL_W = $clog2(NUM_CH);

  localparam logic [addr_witdth-1:0] A_SELECT = addr_witdth'(32'h00);
  localparam logic [addr_witdth-1:0] A_ORDER  = addr_witdth'(32'h04);
  localparam logic [addr_witdth-1:0] A_COUNT  = addr_witdth'(32'h08);
  localparam logic [addr_witdth-1:0] A_KEY    = addr_witdth'(32'h10);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  // Register file
  logic [SEL_W-1:0]      sel_q;
  logic                  ord_q;
  logic [reg_width-1:0]  cnt_q;
  logic [SYS_DWIDTH-1:0] key_q [NUM_CH];

  // Word being serialised, with the settings captured at acceptance
  logic [0:0]            state_q, state_d;
  logic [K_W-1:0]        k_q, k_d;
  logic [MST_DWIDTH-1:0] word_q, word_d;
  logic [SYS_DWIDTH-1:0] wkey_q, wkey_d;
  logic                  word_ord_q, word_ord_d;
  logic                  valid_d, busy_d;
  logic [SYS_DWIDTH-1:0] data_d;

  // Access decode
  logic                  is_sel, is_ord, is_cnt, is_key, acc, acc_err, wr_ok, rd_ok;
  logic [SEL_W-1:0]      key_idx;
  logic [reg_width-1:0]  rd_val;

  // Symbol k of a word; index 0 is the least significant symbol.
  function automatic logic [SYS_DWIDTH-1:0] pick(input logic [MST_DWIDTH-1:0] w,
                                                 input logic [K_W-1:0] k,
                                                 input logic lsb_first);
    logic [K_W-1:0]        idx;
    logic [MST_DWIDTH-1:0] sh;
    idx = lsb_first ? k : K_W'(N - 1) - k;
    sh  = w >> (32'(idx) * SYS_DWIDTH);
    return sh[SYS_DWIDTH-1:0];
  endfunction

  // Address decode, error qualification and read mux
  always_comb begin
    acc     = read | write;
    is_sel  = (addr == A_SELECT);
    is_ord  = (addr == A_ORDER);
    is_cnt  = (addr == A_COUNT);
    is_key  = (addr >= A_KEY) && (addr < A_KEY + addr_witdth'(NUM_CH));
    key_idx = SEL_W'(addr - A_KEY);
    acc_err = (read && write)
           || !(is_sel || is_ord || is_cnt || is_key)
           || (write && is_cnt)
           || (write && is_sel && (wdata >= reg_width'(NUM_CH)));
    wr_ok   = write && !acc_err;
    rd_ok   = read && !acc_err;
    rd_val  = '0;
    if (is_sel)      rd_val = reg_width'(sel_q);
    else if (is_ord) rd_val = reg_width'(ord_q);
    else if (is_cnt) rd_val = cnt_q;
    else if (is_key) rd_val = reg_width'(key_q[key_idx]);
  end

  // Register file and access response; COUNT reads see the pre-increment value
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= '0;
      ord_q <= 1'b0;
      cnt_q <= '0;
      for (int i = 0; i < NUM_CH; i++) key_q[i] <= '0;
      done  <= 1'b0;
      error <= 1'b0;
      rdata <= '0;
    end else begin
      if (wr_ok) begin
        if (is_sel) sel_q <= SEL_W'(wdata);
        if (is_ord) ord_q <= wdata[0];
        if (is_key) key_q[key_idx] <= SYS_DWIDTH'(wdata);
      end
      if (valid_o) cnt_q <= cnt_q + reg_width'(1);
      done  <= acc;
      error <= acc && acc_err;
      rdata <= rd_ok ? rd_val : '0;
    end
  end

  // FSM state register
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      k_q        <= '0;
      word_q     <= '0;
      wkey_q     <= '0;
      word_ord_q <= 1'b0;
      valid_o    <= 1'b0;
      busy       <= 1'b0;
      data_o     <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      word_q     <= word_d;
      wkey_q     <= wkey_d;
      word_ord_q <= word_ord_d;
      valid_o    <= valid_d;
      busy       <= busy_d;
      data_o     <= data_d;
    end
  end

  // Next state; outputs are precomputed from the next state so they register cleanly
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    word_d     = word_q;
    wkey_d     = wkey_q;
    word_ord_d = word_ord_q;
    // A word is taken in IDLE or on the last symbol, giving gap-free back-to-back words
    if (valid_i && ((state_q == IDLE) || (k_q == K_W'(N - 1)))) begin
      state_d    = SHIFT;
      k_d        = '0;
      word_d     = data_i;
      wkey_d     = key_q[sel_q];
      word_ord_d = ord_q;
    end else begin
      case (state_q)
        SHIFT: begin
          if (k_q == K_W'(N - 1)) state_d = IDLE;
          else                    k_d     = k_q + K_W'(1);
        end
        default: ;
      endcase
    end
    valid_d = (state_d == SHIFT);
    busy_d  = valid_d && (k_d != K_W'(N - 1));
    data_d  = valid_d ? pick(word_d, k_d, word_ord_d) - wkey_d : '0;
  end

endmodule

// File: tb/tb_decryption_stream_core.sv
// Self-checking bench for decryption_stream_core: table-driven register
// accesses, a symbol scoreboard fed from a shadow register model, and
// hand-written sequences for back-to-back words, mid-word key writes and reset.
module tb_decryption_stream_core;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic [31:0] data_i;
  logic        valid_i;
  logic        busy;
  logic [7:0]  data_o;
  logic        valid_o;
  logic [7:0]  addr;
  logic        read, write;
  logic [15:0] wdata, rdata;
  logic        done, error;

  always #5 clk_sys = ~clk_sys;

  decryption_stream_core dut (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .data_i(data_i), .valid_i(valid_i), .busy(busy),
    .data_o(data_o), .valid_o(valid_o),
    .addr(addr), .read(read), .write(write), .wdata(wdata),
    .rdata(rdata), .done(done), .error(error)
  );

  typedef struct { logic [7:0] data; logic last; } sym_t;
  typedef struct {
    logic rd; logic wr; logic [7:0] a; logic [15:0] wd; logic err; logic [15:0] rd_exp;
  } acc_t;

  sym_t        sb_q[$];
  acc_t        tbl[21];
  int          checks = 0, errors = 0;
  int          sym_total = 0, run_len = 0, last_run = 0;
  logic [7:0]  tb_key[4];
  logic [1:0]  tb_sel;
  logic        tb_order;
  logic [31:0] ws[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Expected symbols for a word accepted with the current shadow settings
  task automatic push_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      int   idx;
      sym_t e;
      idx    = tb_order ? k : 3 - k;
      e.data = w[idx*8 +: 8] - tb_key[tb_sel];
      e.last = (k == 3);
      sb_q.push_back(e);
      sym_total++;
    end
  endtask

  task automatic reg_acc(input logic rd, input logic wr, input logic [7:0] a,
                         input logic [15:0] wd, input logic exp_err,
                         input logic [15:0] exp_rd, input string name);
    @(negedge clk_sys);
    chk({name, " done idle"}, done, 1'b0);
    chk({name, " rdata idle"}, rdata, 16'h0);
    read = rd; write = wr; addr = a; wdata = wd;
    @(negedge clk_sys);
    read = 1'b0; write = 1'b0;
    chk({name, " done"}, done, 1'b1);
    chk({name, " error"}, error, exp_err);
    chk({name, " rdata"}, rdata, exp_rd);
    if (wr && !rd && !exp_err) begin
      if (a == 8'h00) tb_sel = wd[1:0];
      if (a == 8'h04) tb_order = wd[0];
      if (a >= 8'h10 && a < 8'h14) tb_key[a - 8'h10] = wd[7:0];
    end
  endtask

  task automatic apply_row(input int i);
    reg_acc(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].err, tbl[i].rd_exp,
            $sformatf("row%0d", i));
  endtask

  // Holds valid_i with each word until it is taken
  task automatic send_words(input logic [31:0] wl[$]);
    foreach (wl[i]) begin
      int guard = 0;
      @(negedge clk_sys);
      valid_i = 1'b1; data_i = wl[i];
      while (busy && guard < 20) begin
        @(negedge clk_sys);
        guard++;
      end
      if (busy) chk("word accept timeout", 32'(busy), 32'h0);
      else push_word(wl[i]);
    end
    @(negedge clk_sys);
    valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (sb_q.size() != 0 && g < 40) begin
      @(negedge clk_sys);
      g++;
    end
    if (sb_q.size() != 0) chk("drain timeout", sb_q.size(), 32'h0);
    repeat (2) @(negedge clk_sys);
  endtask

  // Scoreboard monitor
  always @(negedge clk_sys) begin
    if (rst_n === 1'b1) begin
      if (valid_o) begin
        run_len++;
        if (sb_q.size() == 0) begin
          chk("unexpected symbol", 32'(data_o), 32'hFFFF_FFFF);
        end else begin
          sym_t e;
          e = sb_q.pop_front();
          chk("data_o", data_o, e.data);
          chk("busy in word", busy, !e.last);
        end
      end else begin
        chk("data_o idle", data_o, 8'h00);
        chk("busy idle", busy, 1'b0);
        if (run_len != 0) last_run = run_len;
        run_len = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; valid_i = 1'b0; data_i = '0;
    addr = '0; read = 1'b0; write = 1'b0; wdata = '0;
    tb_key = '{default: 8'h00}; tb_sel = '0; tb_order = 1'b0;

    // {rd, wr, addr, wdata, error, rdata}
    tbl[0]  = '{0, 1, 8'h10, 16'h0001, 0, 16'h0000};
    tbl[1]  = '{0, 1, 8'h00, 16'h0000, 0, 16'h0000};
    tbl[2]  = '{0, 1, 8'h04, 16'h0000, 0, 16'h0000};
    tbl[3]  = '{1, 0, 8'h10, 16'h0000, 0, 16'h0001};
    tbl[4]  = '{0, 1, 8'h00, 16'h0004, 1, 16'h0000};
    tbl[5]  = '{1, 0, 8'h09, 16'h0000, 1, 16'h0000};
    tbl[6]  = '{1, 1, 8'h00, 16'h0001, 1, 16'h0000};
    tbl[7]  = '{0, 1, 8'h08, 16'h1234, 1, 16'h0000};
    tbl[8]  = '{1, 0, 8'h14, 16'h0000, 1, 16'h0000};
    tbl[9]  = '{1, 0, 8'h00, 16'h0000, 0, 16'h0000};
    tbl[10] = '{1, 0, 8'h08, 16'h0000, 0, 16'h0010};
    tbl[11] = '{1, 0, 8'h10, 16'h0000, 0, 16'h0001};
    tbl[12] = '{0, 1, 8'h11, 16'hABCD, 0, 16'h0000};
    tbl[13] = '{1, 0, 8'h11, 16'h0000, 0, 16'h00CD};
    tbl[14] = '{0, 1, 8'h00, 16'h0003, 0, 16'h0000};
    tbl[15] = '{1, 0, 8'h00, 16'h0000, 0, 16'h0003};
    tbl[16] = '{0, 1, 8'h00, 16'h0000, 0, 16'h0000};
    tbl[17] = '{1, 0, 8'h12, 16'h0000, 0, 16'h0003};
    tbl[18] = '{0, 1, 8'h04, 16'hFFFF, 0, 16'h0000};
    tbl[19] = '{1, 0, 8'h04, 16'h0000, 0, 16'h0001};
    tbl[20] = '{0, 1, 8'h04, 16'h0000, 0, 16'h0000};

    repeat (3) @(negedge clk_sys);
    chk("reset busy", busy, 1'b0);
    chk("reset valid_o", valid_o, 1'b0);
    chk("reset data_o", data_o, 8'h00);
    chk("reset done", done, 1'b0);
    chk("reset error", error, 1'b0);
    chk("reset rdata", rdata, 16'h0);
    rst_n = 1'b1;

    // Single word, MSB first, key 1; a word offered while busy must be dropped
    for (int i = 0; i <= 3; i++) apply_row(i);
    @(negedge clk_sys);
    chk("t1 busy before send", busy, 1'b0);
    valid_i = 1'b1; data_i = 32'h4443_4241;
    push_word(data_i);
    @(negedge clk_sys);
    chk("t1 busy on first symbol", busy, 1'b1);
    data_i = 32'hDEAD_BEEF;
    @(negedge clk_sys);
    valid_i = 1'b0;
    wait_idle();
    reg_acc(1, 0, 8'h08, 16'h0, 0, 16'(sym_total), "t1 COUNT");

    // LSB first with key 3, symbols wrap below zero
    reg_acc(0, 1, 8'h04, 16'h0001, 0, 16'h0, "t2 ORDER");
    reg_acc(0, 1, 8'h12, 16'h0003, 0, 16'h0, "t2 KEY_2");
    reg_acc(0, 1, 8'h00, 16'h0002, 0, 16'h0, "t2 SELECT");
    ws = '{32'h0102_0304};
    send_words(ws);
    wait_idle();

    // Back-to-back words with valid_i held high
    reg_acc(0, 1, 8'h00, 16'h0000, 0, 16'h0, "t3 SELECT");
    reg_acc(0, 1, 8'h04, 16'h0000, 0, 16'h0, "t3 ORDER");
    ws = '{32'hAAAA_AAAA, 32'h5555_5555};
    send_words(ws);
    wait_idle();
    chk("t3 contiguous run", last_run, 8);

    // Error cases and register read-back
    for (int i = 4; i <= 20; i++) apply_row(i);

    // Key write during the 2nd symbol only affects the next word
    @(negedge clk_sys);
    valid_i = 1'b1; data_i = 32'h2030_4050;
    push_word(data_i);
    @(negedge clk_sys);
    valid_i = 1'b0;
    @(negedge clk_sys);
    write = 1'b1; addr = 8'h10; wdata = 16'h0010;
    tb_key[0] = 8'h10;
    @(negedge clk_sys);
    write = 1'b0;
    chk("t5 key write done", done, 1'b1);
    chk("t5 key write error", error, 1'b0);
    wait_idle();
    ws = '{32'h2030_4050};
    send_words(ws);
    wait_idle();

    // Reset during the 3rd symbol
    reg_acc(0, 1, 8'h00, 16'h0001, 0, 16'h0, "t6 SELECT");
    @(negedge clk_sys);
    valid_i = 1'b1; data_i = 32'h1122_3344;
    push_word(data_i);
    @(negedge clk_sys);
    valid_i = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 rst valid_o", valid_o, 1'b0);
    chk("t6 rst data_o", data_o, 8'h00);
    chk("t6 rst busy", busy, 1'b0);
    chk("t6 rst done", done, 1'b0);
    chk("t6 rst error", error, 1'b0);
    chk("t6 rst rdata", rdata, 16'h0);
    sb_q.delete();
    sym_total = 0;
    tb_key = '{default: 8'h00}; tb_sel = '0; tb_order = 1'b0;
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b1;
    reg_acc(1, 0, 8'h08, 16'h0, 0, 16'h0000, "t6 COUNT after reset");
    reg_acc(1, 0, 8'h00, 16'h0, 0, 16'h0000, "t6 SELECT after reset");
    reg_acc(0, 1, 8'h10, 16'h0005, 0, 16'h0, "t6 KEY_0");
    ws = '{32'h0A0B_0C0D};
    send_words(ws);
    wait_idle();
    reg_acc(1, 0, 8'h08, 16'h0, 0, 16'(sym_total), "t6 COUNT after word");

    chk("scoreboard drained", sb_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
